// File: rtl/uno_seq.sv
// uno_seq: sequenced unified nonlinear unit for the PE datapath.
//
// A single signed MAC serves four operations:
//   op 00 MAC  : out = x*y + (acc_en ? previous out : z), one cycle.
//   op 01 div  : y/x by range reduction, Horner polynomial on the reduced
//                variable, then a scale step.
//   op 10 exp  : exp(x) as exp(x_int) * poly(x_frac).
//   op 11 ln   : ln(x) as poly(0.75 - x_norm) + e*ln2.
// Non-MAC results are Q.2FRAC; divide/log with x <= 0 return an error code.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake; op, acc_en, x, y, z with it
//   cf_op, cf_idx       coefficient table select/index (combinational read)
//   cf_data             coefficient c_k, Q.FRAC
//   es_addr, es_data    exp(x_int) table lookup, Q.FRAC
//   out_valid/out_ready result handshake; out_data, out_err held in DONE
module uno_seq #(
    parameter int unsigned BW     = 12,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned ORDER  = 3,
    parameter int unsigned LN2    = 177,
    parameter int unsigned ACC_BW = 2 * BW + 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic              acc_en,
    input  logic [BW-1:0]     x,
    input  logic [BW-1:0]     y,
    input  logic [2*BW-1:0]   z,
    output logic [1:0]        cf_op,
    output logic [2:0]        cf_idx,
    input  logic [BW-1:0]     cf_data,
    output logic [BW-FRAC-1:0] es_addr,
    input  logic [BW-1:0]     es_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_BW-1:0] out_data,
    output logic              out_err
);

    localparam logic [1:0] OpMac = 2'b00;
    localparam logic [1:0] OpDiv = 2'b01;
    localparam logic [1:0] OpExp = 2'b10;
    localparam logic [1:0] OpLog = 2'b11;

    localparam int unsigned LZW = $clog2(BW + 1);
    localparam int unsigned EW  = LZW + 1;

    localparam logic signed [ACC_BW-1:0] SatMax = ACC_BW'((1 << (BW - 1)) - 1);
    localparam logic signed [ACC_BW-1:0] SatMin = ~SatMax;
    localparam logic signed [ACC_BW-1:0] LnTwo  = ACC_BW'(LN2);
    localparam logic [BW-1:0]            ThreeQuarter = BW'(3 << (FRAC - 2));
    localparam logic signed [BW-1:0]     OneQ   = BW'(1 << FRAC);
    localparam logic [ACC_BW-1:0]        ErrVal = {1'b0, {(ACC_BW - 1){1'b1}}};

    typedef enum logic [2:0] {StIdle, StPre, StHorn, StScale, StDone} state_e;

    state_e                    state_q, state_d;
    logic [1:0]                op_q, op_d;
    logic [BW-1:0]             x_q, x_d;
    logic [BW-1:0]             y_q, y_d;
    logic signed [ACC_BW-1:0]  acc_q, acc_d;
    logic signed [BW-1:0]      var_x_q, var_x_d;
    logic signed [BW-1:0]      scale_q, scale_d;
    logic signed [ACC_BW-1:0]  offset_q, offset_d;
    logic [2:0]                k_q, k_d;
    logic [ACC_BW-1:0]         out_data_q, out_data_d;
    logic                      out_err_q, out_err_d;

    // Leading zeros over the full operand width.
    function automatic logic [LZW-1:0] count_lz(input logic [BW-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = BW - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + LZW'(1);
                end
            end
        end
        return n;
    endfunction

    // Drop the fraction bits of an accumulator and clamp to operand range.
    function automatic logic signed [BW-1:0] sat_bw(input logic signed [ACC_BW-1:0] a);
        logic signed [ACC_BW-1:0] s;
        s = a >>> FRAC;
        if (s > SatMax) begin
            return BW'(SatMax);
        end else if (s < SatMin) begin
            return BW'(SatMin);
        end
        return BW'(s);
    endfunction

    // Datapath signals
    logic                      x_nonpos;
    logic [LZW-1:0]            lz;
    logic [FRAC-1:0]           x_norm;
    logic signed [EW-1:0]      e;
    logic [EW-1:0]             e_mag;
    logic signed [BW-1:0]      div_scale;
    logic signed [BW-1:0]      var_norm;
    logic signed [BW-1:0]      var_frac;
    logic signed [ACC_BW-1:0]  e_ext;
    logic signed [ACC_BW-1:0]  log_offset;
    logic signed [ACC_BW-1:0]  cf_term;
    logic signed [BW-1:0]      acc_sat;
    logic signed [2*BW-1:0]    horn_p;
    logic signed [ACC_BW-1:0]  horn_next;
    logic signed [2*BW-1:0]    scale_p;
    logic signed [ACC_BW-1:0]  scale_next;
    logic signed [2*BW-1:0]    mac_p;
    logic [ACC_BW-1:0]         mac_add;
    logic [ACC_BW-1:0]         mac_res;
    logic [BW-FRAC-1:0]        x_int;

    always_comb begin
        x_nonpos = x[BW-1] || (x == '0);

        // Range reduction: x = x_norm * 2^e with x_norm in [0.5, 1).
        lz       = count_lz(x_q);
        x_norm   = FRAC'((x_q << lz) >> (BW - FRAC));
        e        = $signed(EW'(BW - FRAC)) - $signed({1'b0, lz});
        e_mag    = e[EW-1] ? (~e + EW'(1)) : e;
        div_scale = e[EW-1] ? $signed(y_q << e_mag) : ($signed(y_q) >>> e_mag);
        var_norm = $signed(ThreeQuarter - {{(BW - FRAC){1'b0}}, x_norm});
        var_frac = $signed({{(BW - FRAC){1'b0}}, x_q[FRAC-1:0]});
        x_int    = x_q[BW-1:FRAC];
        e_ext    = $signed({{(ACC_BW - EW){e[EW-1]}}, e});
        log_offset = (e_ext * LnTwo) <<< FRAC;

        // Shared multiply-add for the Horner and scale steps.
        cf_term    = $signed({{(ACC_BW - BW){cf_data[BW-1]}}, cf_data}) <<< FRAC;
        acc_sat    = sat_bw(acc_q);
        horn_p     = acc_sat * var_x_q;
        horn_next  = $signed({{(ACC_BW - 2 * BW){horn_p[2*BW-1]}}, horn_p}) + cf_term;
        scale_p    = acc_sat * scale_q;
        scale_next = $signed({{(ACC_BW - 2 * BW){scale_p[2*BW-1]}}, scale_p}) + offset_q;

        // MAC uses the live request; acc_en chains onto the held result.
        mac_p   = $signed(x) * $signed(y);
        mac_add = acc_en ? out_data_q : {{(ACC_BW - 2 * BW){z[2*BW-1]}}, z};
        mac_res = {{(ACC_BW - 2 * BW){mac_p[2*BW-1]}}, mac_p} + mac_add;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        x_d        = x_q;
        y_d        = y_q;
        acc_d      = acc_q;
        var_x_d    = var_x_q;
        scale_d    = scale_q;
        offset_d   = offset_q;
        k_d        = k_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        cf_idx     = '0;
        es_addr    = '0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d = op;
                    x_d  = x;
                    y_d  = y;
                    if (op == OpMac) begin
                        out_data_d = mac_res;
                        out_err_d  = 1'b0;
                        state_d    = StDone;
                    end else if ((op != OpExp) && x_nonpos) begin
                        out_data_d = ErrVal;
                        out_err_d  = 1'b1;
                        state_d    = StDone;
                    end else begin
                        state_d = StPre;
                    end
                end
            end
            StPre: begin
                cf_idx  = 3'(ORDER);
                es_addr = x_int;
                if (op_q == OpExp) begin
                    var_x_d  = var_frac;
                    scale_d  = $signed(es_data);
                    offset_d = '0;
                end else if (op_q == OpLog) begin
                    var_x_d  = var_norm;
                    scale_d  = OneQ;
                    offset_d = log_offset;
                end else begin
                    var_x_d  = var_norm;
                    scale_d  = div_scale;
                    offset_d = '0;
                end
                acc_d   = cf_term;
                k_d     = 3'(ORDER - 1);
                state_d = StHorn;
            end
            StHorn: begin
                cf_idx  = k_q;
                es_addr = x_int;
                acc_d   = horn_next;
                if (k_q == 3'd0) begin
                    state_d = StScale;
                end else begin
                    k_d = k_q - 3'd1;
                end
            end
            StScale: begin
                acc_d      = scale_next;
                out_data_d = scale_next;
                out_err_d  = 1'b0;
                state_d    = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= OpMac;
            x_q        <= '0;
            y_q        <= '0;
            acc_q      <= '0;
            var_x_q    <= '0;
            scale_q    <= '0;
            offset_q   <= '0;
            k_q        <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            x_q        <= x_d;
            y_q        <= y_d;
            acc_q      <= acc_d;
            var_x_q    <= var_x_d;
            scale_q    <= scale_d;
            offset_q   <= offset_d;
            k_q        <= k_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    assign cf_op    = op_q;
    assign out_data = out_data_q;
    assign out_err  = out_err_q;

endmodule
